// File: rtl/pe_rs_pkg.sv
// Shared types, default geometry and the config-legality check for the row-stationary PE.
package pe_rs_pkg;

    localparam int unsigned DATA_W_DEF      = 16;
    localparam int unsigned ACC_W_DEF       = 32;
    localparam int unsigned IFMAP_DEPTH_DEF = 12;
    localparam int unsigned FILT_DEPTH_DEF  = 224;
    localparam int unsigned PSUM_DEPTH_DEF  = 24;
    localparam int unsigned MUL_LAT_DEF     = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COMPUTE,
        FLUSH,
        DRAIN
    } pe_state_t;

    function automatic logic cfg_legal(
        input logic [4:0]  fw,
        input logic [4:0]  ic,
        input logic [4:0]  oc,
        input int unsigned if_depth,
        input int unsigned filt_depth,
        input int unsigned psum_depth
    );
        logic [31:0] n_if;
        logic [31:0] n_f;
        n_if = {27'd0, fw} * {27'd0, ic};
        n_f  = n_if * {27'd0, oc};
        return (fw != 5'd0) && (ic != 5'd0) && (oc != 5'd0) &&
               (n_if <= if_depth) && (n_f <= filt_depth) &&
               ({27'd0, oc} <= psum_depth);
    endfunction

endpackage

// File: rtl/pe_rs_param_if.sv
// Load, vertical-psum and output-psum streams of the row-stationary PE.
interface pe_rs_param_if
    import pe_rs_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ACC_W  = ACC_W_DEF
);
    logic                     ifmap_valid;
    logic                     ifmap_ready;
    logic signed [DATA_W-1:0] ifmap_data;
    logic                     filt_valid;
    logic                     filt_ready;
    logic signed [DATA_W-1:0] filt_data;
    logic                     ipsum_valid;
    logic                     ipsum_ready;
    logic signed [ACC_W-1:0]  ipsum_data;
    logic                     opsum_valid;
    logic                     opsum_ready;
    logic signed [ACC_W-1:0]  opsum_data;

    modport master (
        output ifmap_valid, ifmap_data, input ifmap_ready,
        output filt_valid, filt_data, input filt_ready,
        output ipsum_valid, ipsum_data, input ipsum_ready,
        input opsum_valid, opsum_data, output opsum_ready
    );

    modport slave (
        input ifmap_valid, ifmap_data, output ifmap_ready,
        input filt_valid, filt_data, output filt_ready,
        input ipsum_valid, ipsum_data, output ipsum_ready,
        output opsum_valid, opsum_data, input opsum_ready
    );

endinterface

// File: rtl/pe_rs_mult.sv
// MUL_LAT-stage signed multiplier; valid bit and psum index ride alongside the product.
module pe_rs_mult
    import pe_rs_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned IDX_W   = 5,
    parameter int unsigned MUL_LAT = MUL_LAT_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [IDX_W-1:0]           in_idx,
    input  logic signed [DATA_W-1:0]   in_a,
    input  logic signed [DATA_W-1:0]   in_b,
    output logic                       out_valid,
    output logic [IDX_W-1:0]           out_idx,
    output logic signed [2*DATA_W-1:0] out_prod
);

    logic [MUL_LAT-1:0]         v_q;
    logic [IDX_W-1:0]           idx_q  [MUL_LAT];
    logic signed [2*DATA_W-1:0] prod_q [MUL_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
        end else begin
            v_q[0] <= in_valid;
            for (int unsigned i = 1; i < MUL_LAT; i++) begin
                v_q[i] <= v_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        prod_q[0] <= (2*DATA_W)'(in_a) * (2*DATA_W)'(in_b);
        idx_q[0]  <= in_idx;
        for (int unsigned i = 1; i < MUL_LAT; i++) begin
            prod_q[i] <= prod_q[i-1];
            idx_q[i]  <= idx_q[i-1];
        end
    end

    assign out_valid = v_q[MUL_LAT-1];
    assign out_idx   = idx_q[MUL_LAT-1];
    assign out_prod  = prod_q[MUL_LAT-1];

endmodule

// File: rtl/pe_rs_param.sv
// Row-stationary PE: load spads, run fw*ic*oc MACs into a psum bank, drain oc psums.
module pe_rs_param
    import pe_rs_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned ACC_W       = ACC_W_DEF,
    parameter int unsigned IFMAP_DEPTH = IFMAP_DEPTH_DEF,
    parameter int unsigned FILT_DEPTH  = FILT_DEPTH_DEF,
    parameter int unsigned PSUM_DEPTH  = PSUM_DEPTH_DEF,
    parameter int unsigned MUL_LAT     = MUL_LAT_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cfg_start,
    input  logic [4:0]   cfg_fw,
    input  logic [4:0]   cfg_ic,
    input  logic [4:0]   cfg_oc,
    input  logic         cfg_reuse_filt,
    input  logic         cfg_bypass_ipsum,
    pe_rs_param_if.slave bus,
    output logic         busy,
    output logic         done,
    output logic         cfg_err
);

    localparam int unsigned IF_AW   = (IFMAP_DEPTH > 1) ? $clog2(IFMAP_DEPTH) : 1;
    localparam int unsigned FILT_AW = (FILT_DEPTH > 1) ? $clog2(FILT_DEPTH) : 1;
    localparam int unsigned PSUM_AW = (PSUM_DEPTH > 1) ? $clog2(PSUM_DEPTH) : 1;

    pe_state_t state;

    logic signed [DATA_W-1:0] ifmap_spad [IFMAP_DEPTH];
    logic signed [DATA_W-1:0] filt_spad  [FILT_DEPTH];
    logic signed [ACC_W-1:0]  psum       [PSUM_DEPTH];

    // Terminal indices (count-1) are latched: a legal config always has count >= 1.
    logic [IF_AW-1:0]   last_if, if_cnt, i_idx;
    logic [FILT_AW-1:0] last_f, f_cnt, f_idx;
    logic [PSUM_AW-1:0] last_p, p_cnt;
    logic [7:0]         fl_cnt;
    logic               if_done, f_done, bypass_q;

    logic        cfg_ok;
    logic [9:0]  n_if_c;
    logic [14:0] n_f_c;

    assign n_if_c = {5'd0, cfg_fw} * {5'd0, cfg_ic};
    assign n_f_c  = {5'd0, n_if_c} * {10'd0, cfg_oc};
    assign cfg_ok = cfg_legal(cfg_fw, cfg_ic, cfg_oc, IFMAP_DEPTH, FILT_DEPTH, PSUM_DEPTH);
    assign busy   = (state != IDLE);

    logic                       mul_valid;
    logic [PSUM_AW-1:0]         mul_idx;
    logic signed [2*DATA_W-1:0] mul_prod;
    logic signed [ACC_W-1:0]    prod_ext;

    pe_rs_mult #(
        .DATA_W  (DATA_W),
        .IDX_W   (PSUM_AW),
        .MUL_LAT (MUL_LAT)
    ) u_mult (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (state == COMPUTE),
        .in_idx    (p_cnt),
        .in_a      (ifmap_spad[i_idx]),
        .in_b      (filt_spad[f_idx]),
        .out_valid (mul_valid),
        .out_idx   (mul_idx),
        .out_prod  (mul_prod)
    );

    assign prod_ext = ACC_W'(mul_prod);

    always_ff @(posedge clk) begin
        if (state == LOAD && bus.ifmap_valid && bus.ifmap_ready) ifmap_spad[if_cnt] <= bus.ifmap_data;
        if (state == LOAD && bus.filt_valid && bus.filt_ready) filt_spad[f_cnt] <= bus.filt_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < PSUM_DEPTH; i++) psum[i] <= '0;
        end else if (state == IDLE && cfg_start && cfg_ok) begin
            for (int unsigned i = 0; i < PSUM_DEPTH; i++) psum[i] <= '0;
        end else if (mul_valid) begin
            psum[mul_idx] <= psum[mul_idx] + prod_ext;
        end
    end

    always_comb begin
        bus.opsum_valid = 1'b0;
        bus.opsum_data  = '0;
        bus.ipsum_ready = 1'b0;
        if (state == DRAIN) begin
            if (bypass_q) begin
                bus.opsum_valid = 1'b1;
                bus.opsum_data  = psum[p_cnt];
            end else begin
                bus.opsum_valid = bus.ipsum_valid;
                bus.opsum_data  = psum[p_cnt] + bus.ipsum_data;
                bus.ipsum_ready = bus.opsum_ready & bus.ipsum_valid;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            bus.ifmap_ready <= 1'b0;
            bus.filt_ready  <= 1'b0;
            done            <= 1'b0;
            cfg_err         <= 1'b0;
            last_if         <= '0;
            last_f          <= '0;
            last_p          <= '0;
            if_cnt          <= '0;
            f_cnt           <= '0;
            i_idx           <= '0;
            f_idx           <= '0;
            p_cnt           <= '0;
            fl_cnt          <= '0;
            if_done         <= 1'b0;
            f_done          <= 1'b0;
            bypass_q        <= 1'b0;
        end else begin
            done    <= 1'b0;
            cfg_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cfg_start) begin
                        if (cfg_ok) begin
                            state           <= LOAD;
                            last_if         <= IF_AW'(n_if_c - 10'd1);
                            last_f          <= FILT_AW'(n_f_c - 15'd1);
                            last_p          <= PSUM_AW'(cfg_oc - 5'd1);
                            bypass_q        <= cfg_bypass_ipsum;
                            if_cnt          <= '0;
                            f_cnt           <= '0;
                            if_done         <= 1'b0;
                            f_done          <= cfg_reuse_filt;
                            bus.ifmap_ready <= 1'b1;
                            bus.filt_ready  <= !cfg_reuse_filt;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (bus.ifmap_valid && bus.ifmap_ready) begin
                        if (if_cnt == last_if) begin
                            bus.ifmap_ready <= 1'b0;
                            if_done         <= 1'b1;
                        end else begin
                            if_cnt <= if_cnt + IF_AW'(1);
                        end
                    end
                    if (bus.filt_valid && bus.filt_ready) begin
                        if (f_cnt == last_f) begin
                            bus.filt_ready <= 1'b0;
                            f_done         <= 1'b1;
                        end else begin
                            f_cnt <= f_cnt + FILT_AW'(1);
                        end
                    end
                    if (if_done && f_done) begin
                        state <= COMPUTE;
                        i_idx <= '0;
                        f_idx <= '0;
                        p_cnt <= '0;
                    end
                end
                // Filter address (s*ic+c)*oc+p is simply sequential; ifmap address steps when p wraps.
                COMPUTE: begin
                    if (f_idx == last_f) begin
                        state  <= FLUSH;
                        fl_cnt <= '0;
                        p_cnt  <= '0;
                    end else begin
                        f_idx <= f_idx + FILT_AW'(1);
                        if (p_cnt == last_p) begin
                            p_cnt <= '0;
                            i_idx <= i_idx + IF_AW'(1);
                        end else begin
                            p_cnt <= p_cnt + PSUM_AW'(1);
                        end
                    end
                end
                FLUSH: begin
                    if (fl_cnt == 8'(MUL_LAT - 1)) state <= DRAIN;
                    else fl_cnt <= fl_cnt + 8'd1;
                end
                DRAIN: begin
                    if (bus.opsum_valid && bus.opsum_ready) begin
                        if (p_cnt == last_p) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            p_cnt <= p_cnt + PSUM_AW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_rs_param.sv
// Directed bench for pe_rs_param with a queue scoreboard checked by an opsum monitor.
module tb_pe_rs_param;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned ACC_W   = 32;
    localparam int unsigned MUL_LAT = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_start;
    logic [4:0] cfg_fw, cfg_ic, cfg_oc;
    logic       cfg_reuse_filt, cfg_bypass_ipsum;
    logic       busy, done, cfg_err;

    pe_rs_param_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

    pe_rs_param #(
        .DATA_W      (DATA_W),
        .ACC_W       (ACC_W),
        .IFMAP_DEPTH (12),
        .FILT_DEPTH  (224),
        .PSUM_DEPTH  (24),
        .MUL_LAT     (MUL_LAT)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cfg_start        (cfg_start),
        .cfg_fw           (cfg_fw),
        .cfg_ic           (cfg_ic),
        .cfg_oc           (cfg_oc),
        .cfg_reuse_filt   (cfg_reuse_filt),
        .cfg_bypass_ipsum (cfg_bypass_ipsum),
        .bus              (bus),
        .busy             (busy),
        .done             (done),
        .cfg_err          (cfg_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic signed [ACC_W-1:0]  exp_q [$];
    logic signed [DATA_W-1:0] ifm [16];
    logic signed [DATA_W-1:0] flt [16];
    logic signed [ACC_W-1:0]  ips [8];
    bit saw_filt_ready;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    // Scoreboard monitor: every opsum transfer pops one expected value.
    always @(negedge clk) begin
        if (rst_n && bus.opsum_valid && bus.opsum_ready) begin
            if (exp_q.size() == 0) begin
                chk("opsum_unexpected", bus.opsum_data, 64'sd0);
                if (bus.opsum_data == '0) begin
                    n_fail++;
                    $display("FAIL opsum_unexpected: actual transfer required none");
                end
            end else begin
                chk("opsum", bus.opsum_data, exp_q.pop_front());
            end
        end
    end

    task automatic start_cfg(input int fw, input int ic, input int oc, input bit reuse, input bit byp);
        @(posedge clk); #1;
        cfg_fw = 5'(fw); cfg_ic = 5'(ic); cfg_oc = 5'(oc);
        cfg_reuse_filt = reuse; cfg_bypass_ipsum = byp; cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
    endtask

    task automatic load(input int nif, input int nf);
        int i = 0, j = 0, cyc = 0;
        bit ai, af;
        saw_filt_ready = 0;
        while ((i < nif || j < nf) && cyc < 300) begin
            bus.ifmap_valid = (i < nif);
            bus.ifmap_data  = (i < nif) ? ifm[i] : '0;
            bus.filt_valid  = (j < nf);
            bus.filt_data   = (j < nf) ? flt[j] : '0;
            @(negedge clk);
            if (bus.filt_ready) saw_filt_ready = 1;
            ai = bus.ifmap_valid && bus.ifmap_ready;
            af = bus.filt_valid && bus.filt_ready;
            @(posedge clk); #1;
            if (ai) i++;
            if (af) j++;
            cyc++;
        end
        bus.ifmap_valid = 1'b0;
        bus.filt_valid  = 1'b0;
        chk("load_ifmap_count", i, nif);
        chk("load_filt_count", j, nf);
    endtask

    task automatic drain(input int oc, input bit byp, input int exp_lat,
                         input int stall_at, input int stall_len, input logic signed [ACC_W-1:0] hold_val);
        int k = 0, cyc = 0, lat = 0, ips_x = 0, st = 0;
        bit seen = 0, ipr_bad = 0;
        bus.ipsum_valid = 1'b1;
        bus.ipsum_data  = ips[0];
        while (k < oc && cyc < 300) begin
            bus.opsum_ready = !(k == stall_at && st < stall_len);
            @(negedge clk);
            if (!seen) begin
                if (bus.opsum_valid) seen = 1;
                else lat++;
            end
            if (byp && bus.ipsum_ready) ipr_bad = 1;
            if (seen && !bus.opsum_ready) begin
                st++;
                chk("stall_valid", bus.opsum_valid, 1);
                chk("stall_hold", bus.opsum_data, hold_val);
            end
            if (bus.ipsum_valid && bus.ipsum_ready) ips_x++;
            if (bus.opsum_valid && bus.opsum_ready) k++;
            @(posedge clk); #1;
            cyc++;
            bus.ipsum_data = (k < 8) ? ips[k] : '0;
        end
        chk("drain_count", k, oc);
        if (exp_lat >= 0) chk("compute_latency", lat, exp_lat);
        if (stall_len > 0) chk("stall_cycles", st, stall_len);
        chk("ipsum_consumed", ips_x, byp ? 0 : oc);
        chk("bypass_ipsum_ready", ipr_bad, 0);
        @(negedge clk);
        chk("done_pulse", done, 1);
        chk("busy_after", busy, 0);
        @(negedge clk);
        chk("done_width", done, 0);
        bus.ipsum_valid = 1'b0;
        bus.opsum_ready = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        chk(name, {busy, done, cfg_err, bus.ifmap_ready, bus.filt_ready,
                   bus.ipsum_ready, bus.opsum_valid}, 0);
        chk({name, "_data"}, bus.opsum_data, 0);
    endtask

    task automatic cfg_reject(input int fw, input int ic, input int oc);
        start_cfg(fw, ic, oc, 0, 0);
        @(negedge clk);
        chk("cfg_err_pulse", cfg_err, 1);
        chk("reject_idle", {busy, bus.ifmap_ready, bus.filt_ready}, 0);
        @(negedge clk);
        chk("cfg_err_width", cfg_err, 0);
        chk("reject_busy", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        cfg_start = 1'b0; cfg_fw = '0; cfg_ic = '0; cfg_oc = '0;
        cfg_reuse_filt = 1'b0; cfg_bypass_ipsum = 1'b0;
        bus.ifmap_valid = 1'b0; bus.ifmap_data = '0;
        bus.filt_valid = 1'b0; bus.filt_data = '0;
        bus.ipsum_valid = 1'b0; bus.ipsum_data = '0;
        bus.opsum_ready = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // fw=3 ic=1 oc=1: 1*4+2*5+3*6 + 10 = 42
        ifm[0] = 1; ifm[1] = 2; ifm[2] = 3;
        flt[0] = 4; flt[1] = 5; flt[2] = 6;
        start_cfg(3, 1, 1, 0, 0);
        load(3, 3);
        ips[0] = 10;
        exp_q.push_back(42);
        drain(1, 0, 1 + 3 + MUL_LAT, -1, 0, 0);

        // fw=1 ic=2 oc=2: p0 = 3*1 - 2*4 = -5, p1 = 3*2 - 2*5 = -4
        ifm[0] = 3; ifm[1] = -2;
        flt[0] = 1; flt[1] = 2; flt[2] = 4; flt[3] = 5;
        start_cfg(1, 2, 2, 0, 0);
        load(2, 4);
        ips[0] = 0; ips[1] = 0;
        exp_q.push_back(-5); exp_q.push_back(-4);
        drain(2, 0, 1 + 4 + MUL_LAT, -1, 0, 0);

        // reuse filters, ifmap 1,1: p0 = 1+4 = 5, p1 = 2+5 = 7
        ifm[0] = 1; ifm[1] = 1;
        start_cfg(1, 2, 2, 1, 0);
        load(2, 0);
        chk("reuse_filt_ready", saw_filt_ready, 0);
        exp_q.push_back(5); exp_q.push_back(7);
        drain(2, 0, 1 + 4 + MUL_LAT, -1, 0, 0);

        // bypass, fw=2 ic=1 oc=3: p = 2*f[p] - 3*f[3+p] -> -10, -11, -12; ipsum ignored
        ifm[0] = 2; ifm[1] = -3;
        for (int i = 0; i < 6; i++) flt[i] = 16'(i + 1);
        start_cfg(2, 1, 3, 0, 1);
        load(2, 6);
        ips[0] = 1000; ips[1] = 1000; ips[2] = 1000;
        exp_q.push_back(-10); exp_q.push_back(-11); exp_q.push_back(-12);
        drain(3, 1, 1 + 6 + MUL_LAT, 1, 3, -11);

        cfg_reject(1, 1, 0);
        cfg_reject(12, 2, 1);

        // reset in the middle of COMPUTE
        for (int i = 0; i < 12; i++) begin
            ifm[i] = 16'(i + 1);
            flt[i] = 16'(i + 2);
        end
        start_cfg(3, 4, 1, 0, 0);
        load(12, 12);
        @(posedge clk); @(posedge clk); #1;
        chk("busy_compute", busy, 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        ifm[0] = 7; flt[0] = -3;
        start_cfg(1, 1, 1, 0, 0);
        load(1, 1);
        ips[0] = 0;
        exp_q.push_back(-21);
        drain(1, 0, 1 + 1 + MUL_LAT, -1, 0, 0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
